// File: rtl/sum_accumulator.sv
// sum_accumulator: sums BURST 9-bit adder results {cout,sum} into an
// ACC_W-bit total and holds it under a valid/ready handshake.
//
// Parameters:
//   ACC_W  accumulator / result width (10..32)
//   BURST  adder results summed per burst (1..255)
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clear               synchronous burst abort (highest priority)
//   in_valid/in_ready   upstream handshake, data = {cout,sum}
//   out_valid/out_ready downstream handshake, data = out_data
//   ovf                 total exceeded 2^ACC_W-1 during the burst
//   count               results accepted in the current burst
// Build option:
//   SUM_ACCUMULATOR_SATURATE_EN  clamp acc at 2^ACC_W-1 instead of wrapping

module sum_accumulator #(
    parameter int ACC_W = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             ovf,
    output logic [7:0]       count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [7:0]       LP_BURST = 8'(BURST);
    localparam logic [ACC_W-1:0] LP_MAX   = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_live;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [ACC_W-1:0] w_val;
    logic [ACC_W:0]   w_add;
    logic             w_carry;
    logic [7:0]       w_count_inc;

    // in_ready stays low until the first edge after reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_ready    = r_live && (r_state != HOLD);
    assign out_valid   = (r_state == HOLD);
    assign out_data    = r_acc;
    assign ovf         = r_ovf;
    assign count       = r_count;

    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = out_valid && out_ready;
    assign w_val       = {{(ACC_W-9){1'b0}}, cout, sum};
    assign w_add       = {1'b0, r_acc} + {1'b0, w_val};
    assign w_carry     = w_add[ACC_W];
    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_count_nxt = r_count;
        if (clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_count_nxt = 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        w_acc_nxt   = w_val;
                        w_ovf_nxt   = 1'b0;
                        w_count_nxt = 8'd1;
                        w_state_nxt = (BURST == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_in_xfer) begin
                        w_ovf_nxt   = r_ovf || w_carry;
                        w_count_nxt = w_count_inc;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                        // once clamped, acc stays at max until reload
                        w_acc_nxt   = (w_carry || r_ovf) ? LP_MAX
                                                         : w_add[ACC_W-1:0];
`else
                        w_acc_nxt   = w_add[ACC_W-1:0];
`endif
                        if (w_count_inc == LP_BURST) begin
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_out_xfer) begin
                        w_state_nxt = IDLE;
                        w_count_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench for sum_accumulator
// (default, ACC_W=10 and BURST=1 instances on shared stimulus).

module tb_sum_accumulator;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic in_valid;
    logic [7:0] sum;
    logic cout;
    logic out_ready;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [15:0] a_out_data;
    logic [7:0]  a_count;
    logic        w_in_ready, w_out_valid, w_ovf;
    logic [9:0]  w_out_data;
    logic [7:0]  w_count;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [15:0] b_out_data;
    logic [7:0]  b_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(16), .BURST(4)) u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .sum(sum), .cout(cout),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .ovf(a_ovf), .count(a_count)
    );

    sum_accumulator #(.ACC_W(10), .BURST(4)) u_w10 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .sum(sum), .cout(cout),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .ovf(w_ovf), .count(w_count)
    );

    sum_accumulator #(.ACC_W(16), .BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .sum(sum), .cout(cout),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .ovf(b_ovf), .count(b_count)
    );

    // reference: step-by-step burst total for width w
    function automatic exp_t model(input int w, input int n, input int v[4]);
        exp_t   r;
        longint mx;
        longint a;
        logic   o;
        mx = (longint'(1) << w) - 1;
        a  = 0;
        o  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                a = v[0];
                o = 1'b0;
            end else begin
                a = a + v[i];
                if (a > mx) begin
                    o = 1'b1;
                    a = SAT ? mx : (a & mx);
                end
            end
        end
        r.d = 32'(a);
        r.o = o;
        return r;
    endfunction

    task automatic drive(input int v);
        {cout, sum} = 9'(v);
        in_valid    = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        sum       = 8'd0;
        cout      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b need 0/0",
                     a_in_ready, a_out_valid);
        end
        n_cmp++;
        if (a_out_data !== 16'd0 || a_ovf !== 1'b0 || a_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: data=%h ovf=%b count=%0d need 0",
                     a_out_data, a_ovf, a_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b/%b need 1",
                     a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_burst;
        int v[4] = '{255, 511, 1, 256};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 ||
                a_count !== 8'(i)) begin
                n_bad++;
                $display("FAIL burst_in%0d: rdy=%b vld=%b cnt=%0d need 1/0/%0d",
                         i, a_in_ready, a_out_valid, a_count, i);
            end
            drive(v[i]);
            if (i == 3) q.push_back(model(16, 4, v));
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== e.d[15:0] ||
            a_ovf !== e.o || a_count !== 8'd4) begin
            n_bad++;
            $display("FAIL burst_out: vld=%b data=%h ovf=%b cnt=%0d need 1/%h/%b/4",
                     a_out_valid, a_out_data, a_ovf, a_count, e.d[15:0], e.o);
        end
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
            a_count !== 8'd0) begin
            n_bad++;
            $display("FAIL burst_after: vld=%b rdy=%b cnt=%0d need 0/1/0",
                     a_out_valid, a_in_ready, a_count);
        end
    endtask

    task automatic test_backpressure;
        int v[4] = '{255, 511, 1, 256};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            if (i == 3) q.push_back(model(16, 4, v));
            @(negedge clk);
        end
        e = q.pop_front();
        // upstream keeps offering data while we hold
        drive(9);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
                a_out_data !== e.d[15:0] || a_count !== 8'd4) begin
                n_bad++;
                $display("FAIL hold_c%0d: vld=%b rdy=%b data=%h cnt=%0d need 1/0/%h/4",
                         c, a_out_valid, a_in_ready, a_out_data, a_count, e.d[15:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== e.d[15:0]) begin
            n_bad++;
            $display("FAIL hold_end: vld=%b data=%h need 1/%h",
                     a_out_valid, a_out_data, e.d[15:0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
            a_count !== 8'd0) begin
            n_bad++;
            $display("FAIL hold_release: vld=%b rdy=%b cnt=%0d need 0/1/0",
                     a_out_valid, a_in_ready, a_count);
        end
    endtask

    task automatic test_overflow;
        int v[4] = '{511, 511, 511, 511};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            if (i == 3) q.push_back(model(10, 4, v));
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if (w_out_valid !== 1'b1 || w_out_data !== e.d[9:0] ||
            w_ovf !== e.o) begin
            n_bad++;
            $display("FAIL ovf_w10: vld=%b data=%h ovf=%b need 1/%h/%b",
                     w_out_valid, w_out_data, w_ovf, e.d[9:0], e.o);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (w_out_valid !== 1'b0 || w_ovf !== e.o || w_out_data !== e.d[9:0]) begin
            n_bad++;
            $display("FAIL ovf_keep: vld=%b ovf=%b data=%h need 0/%b/%h",
                     w_out_valid, w_ovf, w_out_data, e.o, e.d[9:0]);
        end
    endtask

    task automatic test_clear;
        int v[4] = '{1, 1, 1, 1};
        out_ready = 1'b1;
        drive(5);
        @(negedge clk);
        drive(300);
        @(negedge clk);
        n_cmp++;
        if (a_count !== 8'd2) begin
            n_bad++;
            $display("FAIL clr_pre: count=%0d need 2", a_count);
        end
        // input offered alongside clear must be dropped
        drive(77);
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (a_count !== 8'd0 || a_out_data !== 16'd0 || a_ovf !== 1'b0 ||
            a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_post: cnt=%0d data=%h ovf=%b rdy=%b need 0/0/0/1",
                     a_count, a_out_data, a_ovf, a_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            if (i == 3) q.push_back(model(16, 4, v));
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== e.d[15:0]) begin
            n_bad++;
            $display("FAIL clr_burst: vld=%b data=%h need 1/%h",
                     a_out_valid, a_out_data, e.d[15:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        bit seen;
        out_ready = 1'b1;
        drive(40);
        @(negedge clk);
        drive(50);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (a_count !== 8'd2 || a_out_data !== 16'd90) begin
            n_bad++;
            $display("FAIL arst_pre: cnt=%0d data=%0d need 2/90",
                     a_count, a_out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_count !== 8'd0 || a_out_data !== 16'd0 || a_ovf !== 1'b0 ||
            a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_now: cnt=%0d data=%h ovf=%b rdy=%b vld=%b need 0",
                     a_count, a_out_data, a_ovf, a_in_ready, a_out_valid);
        end
        seen = 1'b0;
        drive(60);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || a_in_ready !== 1'b1 || a_count !== 8'd0) begin
            n_bad++;
            $display("FAIL arst_after: vld_seen=%b rdy=%b cnt=%0d need 0/1/0",
                     seen, a_in_ready, a_count);
        end
    endtask

    task automatic test_burst1;
        int v[4] = '{17, 256, 511, 0};
        int one[4];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            one = '{v[i], 0, 0, 0};
            n_cmp++;
            if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL b1_idle%0d: rdy=%b vld=%b need 1/0",
                         i, b_in_ready, b_out_valid);
            end
            drive(v[i]);
            q.push_back(model(16, 1, one));
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            n_cmp++;
            if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 ||
                b_out_data !== e.d[15:0] || b_count !== 8'd1 ||
                b_ovf !== e.o) begin
                n_bad++;
                $display("FAIL b1_out%0d: vld=%b rdy=%b data=%h cnt=%0d need 1/0/%h/1",
                         i, b_out_valid, b_in_ready, b_out_data, b_count, e.d[15:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_left: queue=%0d need 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_reset();
        test_overflow();
        test_reset();
        test_clear();
        test_async_reset();
        test_reset();
        test_burst1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
